redmule_w_load_sched: RTL and testbench

Weight-row load scheduler for the RedMulE datapath. It sits between the top-level controller and the W source streamer. On a start pulse it issues one address request per W row, and it repeats the full W row sequence once per Z tile (pass), rotating the column-tile base address across passes. Issue is throttled by W-buffer credits and by an outstanding-request limit. It returns a registered `w_loaded_o` pulse per completed row, which the controller uses for its row counting.

---
 rtl/redmule_w_load_sched.sv | 163 ++++++++++++++++
 tb/tb_redmule_w_load_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_w_load_sched.sv
// W-row load scheduler: issues one address request per W row, repeated once per Z tile,
// rotating the column-tile base each pass; throttled by buffer credits and an outstanding limit.
module redmule_w_load_sched #(
  parameter int unsigned Height         = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [15:0] w_rows_iter_i,
  input  logic [15:0] tot_passes_i,
  input  logic [15:0] n_col_tiles_i,
  input  logic [31:0] w_base_addr_i,
  input  logic [31:0] w_row_stride_i,
  input  logic [31:0] w_col_offset_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  input  logic        row_done_i,
  input  logic        w_consumed_i,
  output logic        w_loaded_o,
  output logic        last_row_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned CredW = $clog2(Height + 1);
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [15:0]       rows_q, passes_q, ncol_q;
  logic [31:0]       base_q, stride_q, offset_q;
  logic [15:0]       row_q, pass_q, col_q;
  logic [CredW-1:0]  credits_q;
  logic [OutW-1:0]   outst_q;
  logic [31:0]       row_addr_q, col_base_q;
  logic [MaxOutstanding-1:0] last_fifo_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic              w_loaded_q, last_row_q, err_q;

  logic        start_ok, cfg_zero, hs, row_end, last_req, col_wrap;
  logic        done_ok, spurious_done, cred_sat, pop_tag;
  logic [31:0] next_col_base;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign start_ok      = start_i && (state_q == IDLE);
  assign cfg_zero      = (w_rows_iter_i == '0) || (tot_passes_i == '0) || (n_col_tiles_i == '0);
  assign hs            = req_valid_o && req_ready_i;
  assign row_end       = (row_q == rows_q - 16'd1);
  assign last_req      = row_end && (pass_q == passes_q - 16'd1);
  assign col_wrap      = (col_q == ncol_q - 16'd1);
  assign next_col_base = col_wrap ? base_q : col_base_q + offset_q;
  // A completion with nothing outstanding is only legal if it pairs with a same-cycle issue.
  assign done_ok       = row_done_i && ((outst_q != '0) || hs);
  assign spurious_done = row_done_i && !done_ok;
  assign cred_sat      = w_consumed_i && !hs && (credits_q == CredW'(Height));
  assign pop_tag       = (outst_q != '0) ? last_fifo_q[rd_ptr_q] : row_end;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = cfg_zero ? DONE : LOAD;
      LOAD:    if (hs && last_req) state_d = DRAIN;
      DRAIN:   if (outst_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid_o = (state_q == LOAD) && (credits_q != '0) && (outst_q < OutW'(MaxOutstanding));
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
  end

  assign req_addr_o = row_addr_q;
  assign w_loaded_o = w_loaded_q;
  assign last_row_o = last_row_q;
  assign err_o      = err_q;

  // Configuration and tag storage carry no reset; they are rewritten before use.
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      rows_q   <= w_rows_iter_i;
      passes_q <= tot_passes_i;
      ncol_q   <= n_col_tiles_i;
      base_q   <= w_base_addr_i;
      stride_q <= w_row_stride_i;
      offset_q <= w_col_offset_i;
    end
    if (hs) last_fifo_q[wr_ptr_q] <= row_end;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      row_q      <= '0;
      pass_q     <= '0;
      col_q      <= '0;
      credits_q  <= '0;
      outst_q    <= '0;
      row_addr_q <= '0;
      col_base_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      w_loaded_q <= 1'b0;
      last_row_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      w_loaded_q <= done_ok;
      last_row_q <= done_ok && pop_tag;
      err_q      <= start_ok ? 1'b0 : (err_q | spurious_done | cred_sat);
      if (start_ok) begin
        row_q      <= '0;
        pass_q     <= '0;
        col_q      <= '0;
        credits_q  <= CredW'(Height);
        outst_q    <= '0;
        row_addr_q <= w_base_addr_i;
        col_base_q <= w_base_addr_i;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (hs && !w_consumed_i)
          credits_q <= credits_q - CredW'(1);
        else if (!hs && w_consumed_i && (credits_q != CredW'(Height)))
          credits_q <= credits_q + CredW'(1);

        if (hs && !done_ok)      outst_q <= outst_q + OutW'(1);
        else if (!hs && done_ok) outst_q <= outst_q - OutW'(1);

        // Column base advances by addition only; a pass boundary jumps to it.
        if (hs) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
          if (row_end) begin
            row_q      <= '0;
            pass_q     <= pass_q + 16'd1;
            col_q      <= col_wrap ? 16'd0 : col_q + 16'd1;
            col_base_q <= next_col_base;
            row_addr_q <= next_col_base;
          end else begin
            row_q      <= row_q + 16'd1;
            row_addr_q <= row_addr_q + stride_q;
          end
        end
        if (done_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_redmule_w_load_sched.sv
// Randomized bench for redmule_w_load_sched: a streamer/engine model drives the block and a
// row-list reference model predicts addresses, throttling, completion pulses and done.
module tb_redmule_w_load_sched;

  localparam int HEIGHT = 4;
  localparam int MAXO   = 2;

  logic        clk = 1'b0;
  logic        rst_ni, clear_i, start_i;
  logic [15:0] w_rows_iter_i, tot_passes_i, n_col_tiles_i;
  logic [31:0] w_base_addr_i, w_row_stride_i, w_col_offset_i;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_addr_o;
  logic        row_done_i, w_consumed_i;
  logic        w_loaded_o, last_row_o, busy_o, done_o, err_o;

  int n_total = 0;
  int n_bad   = 0;

  redmule_w_load_sched #(.Height(HEIGHT), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .w_rows_iter_i(w_rows_iter_i), .tot_passes_i(tot_passes_i), .n_col_tiles_i(n_col_tiles_i),
    .w_base_addr_i(w_base_addr_i), .w_row_stride_i(w_row_stride_i), .w_col_offset_i(w_col_offset_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
    .row_done_i(row_done_i), .w_consumed_i(w_consumed_i),
    .w_loaded_o(w_loaded_o), .last_row_o(last_row_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [38:0] out_vec();
    return {req_valid_o, w_loaded_o, last_row_o, busy_o, done_o, err_o, 1'b0, req_addr_o};
  endfunction

  task automatic do_start(input int rows, input int passes, input int ncol,
                          input logic [31:0] base, input logic [31:0] stride, input logic [31:0] offset);
    w_rows_iter_i  = 16'(rows);
    tot_passes_i   = 16'(passes);
    n_col_tiles_i  = 16'(ncol);
    w_base_addr_i  = base;
    w_row_stride_i = stride;
    w_col_offset_i = offset;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  task automatic do_clear();
    req_ready_i = 1'b0; row_done_i = 1'b0; w_consumed_i = 1'b0;
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
  endtask

  // Full job against the reference model: expected row list is built from the pass/column
  // rules with plain multiplication, and throttling from credit/outstanding bookkeeping.
  task automatic run_job(input int rows, input int passes, input int ncol,
                         input logic [31:0] base, input logic [31:0] stride, input logic [31:0] offset,
                         input int rdy_pct, input int dly_lo, input int dly_hi, input int cons_pct);
    logic [31:0] exp_addr[$];
    bit          exp_last[$];
    int          due_q[$];
    bit          tag_q[$];
    int  total, issued, completed, cred, outst, unconsumed, done_at;
    bit  exp_valid, ready, hs, rd, lt, cons, exp_loaded, exp_lastb, seen_done;
    for (int p = 0; p < passes; p++)
      for (int r = 0; r < rows; r++) begin
        exp_addr.push_back(base + 32'(p % ncol) * offset + 32'(r) * stride);
        exp_last.push_back(r == rows - 1);
      end
    total = rows * passes;
    issued = 0; completed = 0; cred = HEIGHT; outst = 0; unconsumed = 0; done_at = -1;
    exp_loaded = 0; exp_lastb = 0; seen_done = 0;
    do_start(rows, passes, ncol, base, stride, offset);
    chk("job_busy", {31'd0, busy_o}, 32'd1);
    for (int k = 1; k < 3000 && !seen_done; k++) begin
      exp_valid = (issued < total) && (cred > 0) && (outst < MAXO);
      chk("valid", {31'd0, req_valid_o}, {31'd0, exp_valid});
      ready = ($urandom_range(99) < rdy_pct);
      req_ready_i = ready;
      hs = exp_valid && ready;
      if (hs) chk("addr", req_addr_o, exp_addr[issued]);
      rd = (due_q.size() > 0) && (due_q[0] <= k);
      lt = 1'b0;
      if (rd) begin
        void'(due_q.pop_front());
        lt = tag_q.pop_front();
        completed++;
      end
      row_done_i = rd;
      chk("loaded", {31'd0, w_loaded_o}, {31'd0, exp_loaded});
      if (exp_loaded) begin
        chk("last_row", {31'd0, last_row_o}, {31'd0, exp_lastb});
        unconsumed++;
      end
      cons = (unconsumed > 0) && ($urandom_range(99) < cons_pct);
      w_consumed_i = cons;
      if (cons) begin unconsumed--; cred++; end
      chk("done", {31'd0, done_o}, {31'd0, (k == done_at)});
      if (k == done_at) seen_done = 1;
      if (hs) begin
        due_q.push_back(k + $urandom_range(dly_hi, dly_lo));
        tag_q.push_back(exp_last[issued]);
        issued++; cred--; outst++;
      end
      if (rd) begin
        outst--;
        if (completed == total) done_at = k + 2;
      end
      exp_loaded = rd;
      exp_lastb  = lt;
      cyc();
    end
    chk("job_finished", {31'd0, seen_done}, 32'd1);
    chk("job_idle_busy", {31'd0, busy_o}, 32'd0);
    req_ready_i = 1'b0; row_done_i = 1'b0; w_consumed_i = 1'b0;
  endtask

  initial begin
    int  n;
    bit  prev_hs, hs, ok;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    req_ready_i = 1'b0; row_done_i = 1'b0; w_consumed_i = 1'b0;
    w_rows_iter_i = '0; tot_passes_i = '0; n_col_tiles_i = '0;
    w_base_addr_i = '0; w_row_stride_i = '0; w_col_offset_i = '0;
    repeat (3) cyc();
    rst_ni = 1'b1;
    cyc();
    chk("reset_outputs", out_vec()[31:0] | {26'd0, out_vec()[38:33]}, 32'd0);

    // Basic single pass, then column rotation across passes.
    run_job(4, 1, 1, 32'h1000, 32'h20, 32'h0, 100, 2, 2, 100);
    run_job(2, 3, 2, 32'h1000, 32'h20, 32'h100, 100, 1, 3, 100);

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(5, 1), $urandom_range(3, 1), $urandom_range(3, 1),
              $urandom, $urandom, $urandom, $urandom_range(100, 40), 1, 4, $urandom_range(90, 20));

    // Credit stall: completions follow issue by one cycle, so issue and completion overlap.
    do_start(8, 1, 1, 32'h2000, 32'h10, 32'h0);
    req_ready_i = 1'b1; n = 0; prev_hs = 0;
    for (int i = 0; i < 12; i++) begin
      hs = req_valid_o && req_ready_i;
      row_done_i = prev_hs; prev_hs = hs; n += hs;
      cyc();
    end
    row_done_i = 1'b0;
    chk("credit_stall_count", n, 4);
    chk("credit_stall_valid", {31'd0, req_valid_o}, 32'd0);
    w_consumed_i = 1'b1;
    cyc();
    w_consumed_i = 1'b0; n = 0; prev_hs = 0;
    for (int i = 0; i < 6; i++) begin
      hs = req_valid_o && req_ready_i;
      row_done_i = prev_hs; prev_hs = hs; n += hs;
      cyc();
    end
    row_done_i = 1'b0;
    chk("credit_one_more", n, 1);
    chk("credit_no_err", {31'd0, err_o}, 32'd0);
    do_clear();
    chk("clear_outputs", out_vec()[31:0] | {26'd0, out_vec()[38:33]}, 32'd0);

    // Outstanding limit with completions withheld; fresh start restarts at base.
    do_start(8, 1, 1, 32'h3000, 32'h40, 32'h0);
    chk("restart_addr", req_addr_o, 32'h3000);
    req_ready_i = 1'b1; n = 0;
    for (int i = 0; i < 8; i++) begin
      n += (req_valid_o && req_ready_i);
      cyc();
    end
    chk("outst_count", n, MAXO);
    chk("outst_valid", {31'd0, req_valid_o}, 32'd0);
    do_clear();

    // Backpressure: request held stable, then a completion during stall still pulses.
    do_start(4, 1, 1, 32'h4000, 32'h8, 32'h0);
    req_ready_i = 1'b0; ok = 1;
    for (int i = 0; i < 5; i++) begin
      ok &= (req_valid_o === 1'b1) && (req_addr_o === 32'h4000);
      cyc();
    end
    chk("bp_hold", {31'd0, ok}, 32'd1);
    req_ready_i = 1'b1;
    cyc();
    req_ready_i = 1'b0;
    chk("bp_next_addr", req_addr_o, 32'h4008);
    row_done_i = 1'b1;
    cyc();
    row_done_i = 1'b0;
    chk("bp_loaded", {30'd0, w_loaded_o, last_row_o}, 32'd2);
    chk("bp_still_valid", {31'd0, req_valid_o}, 32'd1);
    do_clear();

    // Spurious completion while idle.
    row_done_i = 1'b1;
    cyc();
    row_done_i = 1'b0;
    chk("spurious_err", {31'd0, err_o}, 32'd1);
    chk("spurious_no_pulse", {31'd0, w_loaded_o}, 32'd0);
    cyc();
    chk("err_sticky", {31'd0, err_o}, 32'd1);

    // Zero-row job goes straight to DONE; start also clears the error flag.
    do_start(0, 2, 1, 32'h5000, 32'h10, 32'h0);
    chk("zero_done", {28'd0, done_o, busy_o, req_valid_o, err_o}, 32'hC);
    cyc();
    chk("zero_idle", {29'd0, done_o, busy_o, req_valid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
